// File: rtl/sel_mux_stage_if.sv
// Handshake bundle for sel_mux_stage: upstream select/offer side, downstream output side, and squash.
// The master modport is the environment driving the stage; the slave modport is the stage itself.
interface sel_mux_stage_if #(
  parameter int NBITS   = 32,
  parameter int NINPUTS = 4,
  parameter int SELW    = 2
);
  logic [NINPUTS*NBITS-1:0] in_data;
  logic [SELW-1:0]          sel;
  logic                     in_valid;
  logic                     in_ready;
  logic                     flush;
  logic [NBITS-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     sel_err;

  modport master (
    output in_data,
    output sel,
    output in_valid,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  sel_err
  );

  modport slave (
    input  in_data,
    input  sel,
    input  in_valid,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid,
    output sel_err
  );
endinterface

// File: rtl/sel_mux_stage.sv
// N-way operand select with a registered output, a one-entry skid buffer and synchronous flush.
// Output register plus skid register behave as a 2-entry in-order FIFO; in_ready is registered.
module sel_mux_stage #(
  parameter int NBITS   = 32,
  parameter int NINPUTS = 4,
  parameter int SELW    = 2
) (
  input logic             clk_i,
  input logic             rst_i,
  sel_mux_stage_if.slave  bus
);

  typedef struct packed {
    logic [NBITS-1:0] data;
    logic             err;
  } entry_t;

  // Out-of-range selects yield an all-zero word flagged as an error.
  function automatic entry_t select_word(
    input logic [NINPUTS*NBITS-1:0] words,
    input logic [SELW-1:0]          idx
  );
    entry_t e;
    e.data = {NBITS{1'b0}};
    e.err  = 1'b1;
    for (int i = 0; i < NINPUTS; i++) begin
      if (idx == SELW'(i)) begin
        e.data = words[i*NBITS +: NBITS];
        e.err  = 1'b0;
      end
    end
    return e;
  endfunction

  entry_t or_q, or_d;
  entry_t sk_q, sk_d;
  logic   or_valid_q, or_valid_d;
  logic   sk_valid_q, sk_valid_d;
  logic   in_ready_q, in_ready_d;

  entry_t new_s;
  logic   accept_s;
  logic   drain_s;

  // Input selection and handshake qualifiers; a flush cycle never accepts.
  always_comb begin
    new_s    = select_word(bus.in_data, bus.sel);
    accept_s = bus.in_valid && in_ready_q && !bus.flush;
    drain_s  = or_valid_q && bus.out_ready;
  end

  // Next-state for the output and skid entries.
  always_comb begin
    or_d       = or_q;
    sk_d       = sk_q;
    or_valid_d = or_valid_q;
    sk_valid_d = sk_valid_q;
    if (bus.flush) begin
      or_valid_d = 1'b0;
      sk_valid_d = 1'b0;
    end else if (!or_valid_q || drain_s) begin
      if (sk_valid_q) begin
        or_d       = sk_q;
        or_valid_d = 1'b1;
        sk_valid_d = 1'b0;
      end else if (accept_s) begin
        or_d       = new_s;
        or_valid_d = 1'b1;
      end else begin
        or_valid_d = 1'b0;
      end
    end else begin
      // Output held: a newly accepted entry parks in the skid register.
      if (accept_s) begin
        sk_d       = new_s;
        sk_valid_d = 1'b1;
      end else begin
        sk_valid_d = sk_valid_q;
      end
    end
    in_ready_d = !sk_valid_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      or_q       <= '{data: {NBITS{1'b0}}, err: 1'b0};
      sk_q       <= '{data: {NBITS{1'b0}}, err: 1'b0};
      or_valid_q <= 1'b0;
      sk_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      or_q       <= or_d;
      sk_q       <= sk_d;
      or_valid_q <= or_valid_d;
      sk_valid_q <= sk_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.out_data  = or_q.data;
  assign bus.sel_err   = or_q.err;
  assign bus.out_valid = or_valid_q;
  assign bus.in_ready  = in_ready_q;

endmodule

// File: tb/tb_sel_mux_stage.sv
// Self-checking bench for sel_mux_stage: directed scenarios plus randomized traffic against a queue model.
// A 4-input instance carries the main traffic; a 3-input instance exercises out-of-range selects.
module tb_sel_mux_stage;

  localparam logic [31:0] A0 = 32'h1111_1111;
  localparam logic [31:0] A1 = 32'h2222_2222;
  localparam logic [31:0] A2 = 32'h3333_3333;
  localparam logic [31:0] A3 = 32'h4444_4444;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Reference model: the stage is a 2-deep FIFO of {word, err}.
  logic [31:0] q_data[$];
  logic        q_err[$];

  sel_mux_stage_if #(.NBITS(32), .NINPUTS(4), .SELW(2)) if4 ();
  sel_mux_stage_if #(.NBITS(32), .NINPUTS(3), .SELW(2)) if3 ();

  sel_mux_stage #(.NBITS(32), .NINPUTS(4), .SELW(2)) u_dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if4.slave)
  );

  sel_mux_stage #(.NBITS(32), .NINPUTS(3), .SELW(2)) u_dut3 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if3.slave)
  );

  always #5 clk = ~clk;

  // Advance one clock; the model consumes the inputs presented before the edge.
  task automatic tick();
    logic        acc;
    logic        drn;
    logic [31:0] w;
    logic        e;
    acc = if4.in_valid && (q_data.size() < 2) && !if4.flush;
    drn = (q_data.size() > 0) && if4.out_ready;
    if (int'(if4.sel) < 4) begin
      w = if4.in_data[int'(if4.sel)*32 +: 32];
      e = 1'b0;
    end else begin
      w = 32'h0;
      e = 1'b1;
    end
    if (rst || if4.flush) begin
      q_data.delete();
      q_err.delete();
    end else begin
      if (drn) begin
        void'(q_data.pop_front());
        void'(q_err.pop_front());
      end
      if (acc) begin
        q_data.push_back(w);
        q_err.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (if4.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", if4.out_valid); end
    checks++; if (if4.out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", if4.out_data); end
    checks++; if (if4.sel_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", if4.sel_err); end
    checks++; if (if4.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", if4.in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_basic_select();
    if4.out_ready = 1'b1;
    if4.sel       = 2'd2;
    if4.in_valid  = 1'b1;
    tick();
    if4.in_valid  = 1'b0;
    checks++; if (if4.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", if4.out_valid); end
    checks++; if (if4.out_data !== A2) begin failures++; $display("FAIL basic_data got=%h exp=%h", if4.out_data, A2); end
    checks++; if (if4.sel_err !== 1'b0) begin failures++; $display("FAIL basic_err got=%0b exp=0", if4.sel_err); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w[4];
    exp_w = '{A0, A1, A2, A3};
    if4.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if4.sel      = 2'(k);
      if4.in_valid = 1'b1;
      tick();
      checks++; if (if4.out_data !== exp_w[k] || if4.out_valid !== 1'b1) begin
        failures++; $display("FAIL b2b_data[%0d] got=%h/%0b exp=%h/1", k, if4.out_data, if4.out_valid, exp_w[k]);
      end
      checks++; if (if4.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", k, if4.in_ready); end
    end
    if4.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    if4.out_ready = 1'b0;
    if4.in_valid  = 1'b1;
    if4.sel       = 2'd0;
    tick();
    checks++; if (if4.out_data !== A0 || if4.in_ready !== 1'b1) begin failures++; $display("FAIL stall_w0 got=%h rdy=%0b exp=%h rdy=1", if4.out_data, if4.in_ready, A0); end
    if4.sel = 2'd1;
    tick();
    checks++; if (if4.out_data !== A0 || if4.in_ready !== 1'b0) begin failures++; $display("FAIL stall_w1 got=%h rdy=%0b exp=%h rdy=0", if4.out_data, if4.in_ready, A0); end
    if4.sel = 2'd2;
    tick();
    checks++; if (if4.out_data !== A0 || if4.out_valid !== 1'b1 || if4.in_ready !== 1'b0) begin
      failures++; $display("FAIL stall_hold got=%h v=%0b rdy=%0b exp=%h v=1 rdy=0", if4.out_data, if4.out_valid, if4.in_ready, A0);
    end
    if4.out_ready = 1'b1;
    tick();
    checks++; if (if4.out_data !== A1 || if4.in_ready !== 1'b1) begin failures++; $display("FAIL release_w1 got=%h rdy=%0b exp=%h rdy=1", if4.out_data, if4.in_ready, A1); end
    tick();
    checks++; if (if4.out_data !== A2 || if4.out_valid !== 1'b1) begin failures++; $display("FAIL release_w2 got=%h v=%0b exp=%h v=1", if4.out_data, if4.out_valid, A2); end
    if4.in_valid = 1'b0;
    tick();
    checks++; if (if4.out_valid !== 1'b0) begin failures++; $display("FAIL release_empty got=%0b exp=0", if4.out_valid); end
  endtask

  task automatic test_sel_err();
    if3.in_data   = {A2, A1, A0};
    if3.out_ready = 1'b1;
    if3.sel       = 2'd3;
    if3.in_valid  = 1'b1;
    tick();
    checks++; if (if3.out_valid !== 1'b1 || if3.out_data !== 32'h0 || if3.sel_err !== 1'b1) begin
      failures++; $display("FAIL selerr_oob got=%h err=%0b v=%0b exp=0 err=1 v=1", if3.out_data, if3.sel_err, if3.out_valid);
    end
    if3.sel = 2'd1;
    tick();
    if3.in_valid = 1'b0;
    checks++; if (if3.out_data !== A1 || if3.sel_err !== 1'b0) begin
      failures++; $display("FAIL selerr_ok got=%h err=%0b exp=%h err=0", if3.out_data, if3.sel_err, A1);
    end
    tick();
  endtask

  task automatic test_flush();
    if4.out_ready = 1'b0;
    if4.in_valid  = 1'b1;
    if4.sel       = 2'd0;
    tick();
    if4.sel = 2'd1;
    tick();
    checks++; if (if4.in_ready !== 1'b0) begin failures++; $display("FAIL flush_full got=%0b exp=0", if4.in_ready); end
    if4.flush = 1'b1;
    if4.sel   = 2'd3;
    tick();
    checks++; if (if4.out_valid !== 1'b0 || if4.in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_clear v=%0b rdy=%0b exp v=0 rdy=1", if4.out_valid, if4.in_ready);
    end
    if4.flush     = 1'b0;
    if4.in_valid  = 1'b0;
    if4.out_ready = 1'b1;
    tick();
    checks++; if (if4.out_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%0b exp=0", if4.out_valid); end
    if4.in_valid = 1'b1;
    if4.sel      = 2'd3;
    tick();
    if4.in_valid = 1'b0;
    checks++; if (if4.out_valid !== 1'b1 || if4.out_data !== A3) begin
      failures++; $display("FAIL flush_after got=%h v=%0b exp=%h v=1", if4.out_data, if4.out_valid, A3);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    if4.out_ready = 1'b0;
    if4.in_valid  = 1'b1;
    if4.sel       = 2'd2;
    tick();
    if4.sel = 2'd3;
    tick();
    if4.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (if4.out_valid !== 1'b0 || if4.out_data !== 32'h0 || if4.sel_err !== 1'b0 || if4.in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_stall v=%0b d=%h err=%0b rdy=%0b exp 0/0/0/1", if4.out_valid, if4.out_data, if4.sel_err, if4.in_ready);
    end
    if4.out_ready = 1'b1;
    tick();
    checks++; if (if4.out_valid !== 1'b0) begin failures++; $display("FAIL rst_stall_ghost got=%0b exp=0", if4.out_valid); end
    if4.in_valid = 1'b1;
    if4.sel      = 2'd1;
    tick();
    if4.in_valid = 1'b0;
    checks++; if (if4.out_valid !== 1'b1 || if4.out_data !== A1) begin
      failures++; $display("FAIL rst_stall_next got=%h v=%0b exp=%h v=1", if4.out_data, if4.out_valid, A1);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if4.in_data   = {$urandom, $urandom, $urandom, $urandom};
      if4.sel       = 2'($urandom_range(0, 3));
      if4.in_valid  = 1'($urandom_range(0, 1));
      if4.out_ready = ($urandom_range(0, 2) != 0);
      if4.flush     = ($urandom_range(0, 19) == 0);
      tick();
      checks++; if (if4.out_valid !== (q_data.size() > 0)) begin
        failures++; $display("FAIL rnd_valid[%0d] got=%0b exp=%0b", n, if4.out_valid, q_data.size() > 0);
      end
      checks++; if (if4.in_ready !== (q_data.size() < 2)) begin
        failures++; $display("FAIL rnd_ready[%0d] got=%0b exp=%0b", n, if4.in_ready, q_data.size() < 2);
      end
      if (q_data.size() > 0) begin
        checks++; if (if4.out_data !== q_data[0] || if4.sel_err !== q_err[0]) begin
          failures++; $display("FAIL rnd_data[%0d] got=%h/%0b exp=%h/%0b", n, if4.out_data, if4.sel_err, q_data[0], q_err[0]);
        end
      end
    end
    if4.flush    = 1'b0;
    if4.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    checks   = 0;
    failures = 0;
    if4.in_data   = {A3, A2, A1, A0};
    if4.sel       = 2'd0;
    if4.in_valid  = 1'b0;
    if4.flush     = 1'b0;
    if4.out_ready = 1'b1;
    if3.in_data   = {A2, A1, A0};
    if3.sel       = 2'd0;
    if3.in_valid  = 1'b0;
    if3.flush     = 1'b0;
    if3.out_ready = 1'b1;
    test_reset();
    test_basic_select();
    test_back_to_back();
    test_stall();
    test_sel_err();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
